tape_rec: RTL

Tape recorder front end for the Spectrum core. It measures the half-periods of the CPU's MIC/SAVE output and decodes standard ROM-timed pilot, sync and data pulses into bytes. It writes the result into the tape buffer in TAP format: each block is a 2-byte little-endian length followed by the data bytes. The block sits beside the tape player on the same SDRAM tape region, so a recorded image can be played straight back.

---
 rtl/tape_rec.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tape_rec.sv
// tape_rec: decodes ROM-timed MIC pulses into TAP blocks (len lo/hi + bytes) via a one-entry wr/wr_ack write port (addr/dout); size/blk_cnt/active/chk_err report progress, chk_err needs TAPE_REC_CHECKSUM_EN
module tape_rec #(
  parameter int MIN_PILOT = 256,
  parameter int TIMEOUT = 35000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec,
  input  logic        mic_in,
  output logic        wr,
  input  logic        wr_ack,
  output logic [24:0] addr,
  output logic [7:0]  dout,
  output logic [24:0] size,
  output logic [7:0]  blk_cnt,
  output logic        active,
  output logic        chk_err
);
  typedef enum logic [2:0] {IDLE, PILOT, SYNC2, DATA, FIN, HDR1, CMT} state_t;
  state_t state, state_nx;
  logic [2:0] s;
  logic rec_q, hv, first, full;
  logic [15:0] cnt, bytecnt;
  logic [11:0] pcnt;
  logic [24:0] wptr, blk_start;
  logic [6:0] sh;
  logic [2:0] nbits;
  logic ev, proc, is_short, is_long, is_pilot, rec_rise, pair_ok, byte_done, to_data, commit;
  logic [7:0] byte_v;
  always_comb begin
    ev = (s[2] ^ s[1]) && cnt >= 16'd400;
    proc = ev && rec && !full;
    is_short = cnt <= 16'd1282;
    is_long = cnt >= 16'd1283 && cnt <= 16'd1900;
    is_pilot = cnt >= 16'd1901 && cnt <= 16'd2600;
    rec_rise = rec && !rec_q;
    pair_ok = hv && (is_short || is_long) && first == is_long;
    byte_v = {sh, is_long};
    byte_done = state == DATA && proc && pair_ok && nbits == 3'd7;
    to_data = state == SYNC2 && proc && is_short;
    commit = state == CMT && !wr;
    active = state == SYNC2 || state == DATA;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (proc && is_pilot) state_nx = PILOT;
      PILOT: if (proc) state_nx = is_pilot ? PILOT : (is_short && pcnt >= 12'(MIN_PILOT)) ? SYNC2 : IDLE;
      SYNC2: if (proc) state_nx = is_short ? DATA : IDLE;
      DATA: if (!rec || full || cnt >= 16'(TIMEOUT) || bytecnt == 16'hFFFF ||
                (proc && !(is_short || is_long)) || (proc && hv && first != is_long)) state_nx = FIN;
      FIN: if (!wr) state_nx = bytecnt == 16'd0 ? IDLE : HDR1;
      HDR1: if (!wr) state_nx = CMT;
      CMT: if (!wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (rec_rise) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s <= '0;
      rec_q <= 1'b0;
      cnt <= '0;
      full <= 1'b0;
      wr <= 1'b0;
      addr <= '0;
      dout <= '0;
      pcnt <= '0;
      blk_start <= '0;
      wptr <= '0;
      bytecnt <= '0;
      hv <= 1'b0;
      first <= 1'b0;
      sh <= '0;
      nbits <= '0;
      size <= '0;
      blk_cnt <= '0;
    end else begin
      state <= state_nx;
      s <= {s[1:0], mic_in};
      rec_q <= rec;
      cnt <= ev ? 16'd1 : cnt + {15'd0, cnt != 16'hFFFF};
      full <= !rec_rise && (full || wptr == '1);
      if (wr && wr_ack) wr <= 1'b0;
      if (proc && is_pilot) pcnt <= state == IDLE ? 12'd1 : pcnt + {11'd0, pcnt != 12'hFFF};
      if (to_data) begin
        blk_start <= wptr;
        wptr <= wptr + 25'd2;
        bytecnt <= '0;
        hv <= 1'b0;
        nbits <= '0;
      end
      if (state == DATA && proc && (is_short || is_long)) begin
        hv <= !hv;
        first <= is_long;
        if (pair_ok) begin
          sh <= byte_v[6:0];
          nbits <= nbits + 3'd1;
        end
      end
      if (byte_done) begin
        wr <= 1'b1;
        addr <= wptr;
        dout <= byte_v;
        wptr <= wptr + 25'd1;
        bytecnt <= bytecnt + 16'd1;
      end
      if (state == FIN && !wr) begin
        if (bytecnt == 16'd0) wptr <= blk_start;
        else begin
          wr <= 1'b1;
          addr <= blk_start;
          dout <= bytecnt[7:0];
        end
      end
      if (state == HDR1 && !wr) begin
        wr <= 1'b1;
        addr <= blk_start + 25'd1;
        dout <= bytecnt[15:8];
      end
      if (commit) begin
        size <= wptr;
        blk_cnt <= blk_cnt + 8'd1;
      end
      if (rec_rise) begin
        wptr <= '0;
        size <= '0;
        blk_cnt <= '0;
      end
    end
  end
`ifdef TAPE_REC_CHECKSUM_EN
  logic [7:0] xr;
  always_ff @(posedge clk) begin
    if (reset) begin
      xr <= '0;
      chk_err <= 1'b0;
    end else begin
      if (to_data) xr <= '0;
      if (byte_done) xr <= xr ^ byte_v;
      if (commit) chk_err <= xr != 8'd0;
      if (rec_rise) chk_err <= 1'b0;
    end
  end
`else
  assign chk_err = 1'b0;
`endif
endmodule
